// File: rtl/data2signal.sv
// Serialises SIZE-bit samples to a DAC: sync_n frames the word, sdata is sent MSB first
// and changes only on sclk falling edges. A one-cycle next pulse requests each sample.
module data2signal #(
  parameter int SIZE = 12,
  parameter int DIV  = 2,
  parameter int LAT  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [SIZE-1:0] data,
  output logic            next,
  output logic            sclk,
  output logic            sdata,
  output logic            sync_n,
  output logic            frame_done
);

  // One shared counter times both the WAIT latency and the sclk half-period.
  localparam int CMAX = (DIV > LAT) ? DIV : LAT;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int BW   = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(LAT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SIZE - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, SHIFT, GAP} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_cnt;
  logic [SIZE-1:0] shreg;

  // sdata is the shift register MSB; it is cleared at frame end so GAP/IDLE drive 0.
  assign sdata = shreg[SIZE-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      next       <= 1'b0;
      sclk       <= 1'b0;
      sync_n     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      next       <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          sclk   <= 1'b0;
          sync_n <= 1'b1;
          cnt    <= '0;
          if (enable) begin
            state <= LOAD;
            next  <= 1'b1;
          end
        end
        LOAD: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == LAT_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= data;
            sync_n  <= 1'b0;
            sclk    <= 1'b0;
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // Falling edge: advance to the next bit or close the frame.
              sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt    <= '0;
                shreg      <= '0;
                sync_n     <= 1'b1;
                frame_done <= 1'b1;
                state      <= GAP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {shreg[SIZE-2:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (enable) begin
              state <= LOAD;
              next  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data2signal.sv
// Directed bench for data2signal: default instance plus a DIV=1, LAT=1 instance.
module tb_data2signal;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        enable_a = 1'b0, enable_b = 1'b0;
  logic [11:0] data_a = '0, data_b = '0;
  logic        next_a, sclk_a, sdata_a, sync_n_a, frame_done_a;
  logic        next_b, sclk_b, sdata_b, sync_n_b, frame_done_b;

  data2signal u_a (
    .clk(clk), .rst(rst), .enable(enable_a), .data(data_a),
    .next(next_a), .sclk(sclk_a), .sdata(sdata_a), .sync_n(sync_n_a), .frame_done(frame_done_a)
  );

  data2signal #(.SIZE(12), .DIV(1), .LAT(1)) u_b (
    .clk(clk), .rst(rst), .enable(enable_b), .data(data_b),
    .next(next_b), .sclk(sclk_b), .sdata(sdata_b), .sync_n(sync_n_b), .frame_done(frame_done_b)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor for instance A, sampling on the falling clk edge.
  int          cyc = 0, n_next = 0, n_fr = 0, rx_bits = 0, sync_run = 0, viol = 0;
  logic [11:0] rx_word = '0;
  int          next_cyc [16];
  logic [11:0] fword [16];
  int          fbits [16];
  int          fsync [16];
  logic        sclk_p = 1'b0, sdata_p = 1'b0, sync_p = 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (next_a && n_next < 16) begin
      next_cyc[n_next] <= cyc;
      n_next <= n_next + 1;
    end
    if (!sync_n_a && sclk_a && !sclk_p) begin
      rx_word <= {rx_word[10:0], sdata_a};
      rx_bits <= rx_bits + 1;
    end
    if (!sync_n_a) sync_run <= sync_run + 1;
    if (!sync_n_a && !sync_p && sclk_a && sdata_a != sdata_p) viol <= viol + 1;
    if (frame_done_a && n_fr < 16) begin
      fword[n_fr] <= rx_word;
      fbits[n_fr] <= rx_bits;
      fsync[n_fr] <= sync_run;
      n_fr <= n_fr + 1;
    end
    if (sync_n_a) begin
      rx_word  <= '0;
      rx_bits  <= 0;
      sync_run <= 0;
    end
    sclk_p  <= sclk_a;
    sdata_p <= sdata_a;
    sync_p  <= sync_n_a;
  end

  // Monitor for instance B; also counts SHIFT cycles where sclk failed to toggle.
  int          b_cyc = 0, b_n_next = 0, b_n_fr = 0, b_bits = 0, b_run = 0, b_tog = 0;
  logic [11:0] b_word = '0;
  int          b_next_cyc [8];
  logic [11:0] b_fword [8];
  int          b_fbits [8];
  int          b_fsync [8];
  logic        b_sclk_p = 1'b0, b_sync_p = 1'b1;

  always @(negedge clk) begin
    b_cyc <= b_cyc + 1;
    if (next_b && b_n_next < 8) begin
      b_next_cyc[b_n_next] <= b_cyc;
      b_n_next <= b_n_next + 1;
    end
    if (!sync_n_b && sclk_b && !b_sclk_p) begin
      b_word <= {b_word[10:0], sdata_b};
      b_bits <= b_bits + 1;
    end
    if (!sync_n_b) b_run <= b_run + 1;
    if (!sync_n_b && !b_sync_p && sclk_b == b_sclk_p) b_tog <= b_tog + 1;
    if (frame_done_b && b_n_fr < 8) begin
      b_fword[b_n_fr] <= b_word;
      b_fbits[b_n_fr] <= b_bits;
      b_fsync[b_n_fr] <= b_run;
      b_n_fr <= b_n_fr + 1;
    end
    if (sync_n_b) begin
      b_word <= '0;
      b_bits <= 0;
      b_run  <= 0;
    end
    b_sclk_p <= sclk_b;
    b_sync_p <= sync_n_b;
  end

  // Waits for the next pulse on A, then presents val only on the capture edge (LAT=2).
  task automatic serve(input logic [11:0] val);
    bit got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (next_a) got = 1'b1;
    end
    if (!got) check("next_timeout", n_next, n_next + 1);
    data_a = val ^ 12'($urandom_range(1, 4095));
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      data_a = (k == 2) ? val : (val ^ 12'($urandom_range(1, 4095)));
    end
    @(negedge clk);
    data_a = val ^ 12'($urandom_range(1, 4095));
  endtask

  task automatic wait_frames(input int target);
    for (int k = 0; k < 400 && n_fr < target; k++) begin
      @(negedge clk);
      #1;
    end
    if (n_fr < target) check("frame_timeout", n_fr, target);
  endtask

  task automatic wait_bits(input int target);
    for (int k = 0; k < 200 && rx_bits < target; k++) begin
      @(negedge clk);
      #1;
    end
    if (rx_bits < target) check("bits_timeout", rx_bits, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e_idx;
    int fr_snap;

    repeat (3) @(negedge clk);
    check("rst_next",       next_a,       1'b0);
    check("rst_sclk",       sclk_a,       1'b0);
    check("rst_sdata",      sdata_a,      1'b0);
    check("rst_sync_n",     sync_n_a,     1'b1);
    check("rst_frame_done", frame_done_a, 1'b0);
    rst = 1'b0;

    repeat (5) @(negedge clk);
    #1;
    check("idle_no_next", n_next, 0);
    check("idle_sync_n",  sync_n_a, 1'b1);

    @(negedge clk);
    #1;
    enable_a = 1'b1;
    e_idx = cyc - 1;

    serve(12'hA5C);
    serve(12'h3C9);
    check("fd_once", n_fr, 1);
    serve(12'h801);
    serve(12'h7FE);

    // Frame 5: drop enable after five bits have gone out.
    serve(12'h5A3);
    wait_bits(5);
    enable_a = 1'b0;
    wait_frames(5);
    repeat (120) @(negedge clk);
    #1;
    check("drop_no_next",  n_next, 5);
    check("drop_frames",   n_fr, 5);
    check("drop_word",     fword[4], 12'h5A3);
    check("drop_bits",     fbits[4], 12);
    check("drop_sync_n",   sync_n_a, 1'b1);
    check("drop_sclk",     sclk_a, 1'b0);

    check("en_to_next",    next_cyc[0] - e_idx, 1);
    check("f0_word",       fword[0], 12'hA5C);
    check("f0_bits",       fbits[0], 12);
    check("f0_sync_low",   fsync[0], 48);
    check("f1_word",       fword[1], 12'h3C9);
    check("f2_word",       fword[2], 12'h801);
    check("f3_word",       fword[3], 12'h7FE);
    check("f3_sync_low",   fsync[3], 48);
    check("period_01",     next_cyc[1] - next_cyc[0], 53);
    check("period_12",     next_cyc[2] - next_cyc[1], 53);
    check("period_23",     next_cyc[3] - next_cyc[2], 53);
    check("sdata_stable",  viol, 0);

    // Asynchronous reset in the middle of bit 7.
    enable_a = 1'b1;
    serve(12'hC33);
    wait_bits(7);
    @(posedge clk);
    #2;
    rst = 1'b1;
    fr_snap = n_fr;
    #1;
    check("arst_sync_n", sync_n_a, 1'b1);
    check("arst_sclk",   sclk_a, 1'b0);
    check("arst_sdata",  sdata_a, 1'b0);
    check("arst_next",   next_a, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    check("arst_no_fd",  n_fr, fr_snap);
    @(negedge clk);
    rst = 1'b0;
    serve(12'h96E);
    wait_frames(6);
    check("post_rst_word", fword[5], 12'h96E);
    check("post_rst_bits", fbits[5], 12);
    enable_a = 1'b0;

    // DIV=1, LAT=1 instance streaming all-ones.
    data_b   = 12'hFFF;
    enable_b = 1'b1;
    for (int k = 0; k < 300 && b_n_fr < 3; k++) begin
      @(negedge clk);
      #1;
    end
    if (b_n_fr < 3) check("b_frame_timeout", b_n_fr, 3);
    check("b_word0",    b_fword[0], 12'hFFF);
    check("b_word1",    b_fword[1], 12'hFFF);
    check("b_bits0",    b_fbits[0], 12);
    check("b_sync_low", b_fsync[0], 24);
    check("b_toggle",   b_tog, 0);
    check("b_period01", b_next_cyc[1] - b_next_cyc[0], 27);
    check("b_period12", b_next_cyc[2] - b_next_cyc[1], 27);
    enable_b = 1'b0;

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
